cuckoo_req_frontend: RTL and testbench

Request front-end placed directly upstream of the cuckoo hash table. It buffers incoming key/offset/value requests in a small FIFO and precomputes the three bucket indices in a registered stage. It issues one request at a time to the table over a valid/ready handshake and re-issues a request when the table reports a collision, up to a bounded retry count. Keys equal to zero are the table's empty-slot marker, so the front-end rejects them at the input.

---
 rtl/cuckoo_pkg.sv | 28 ++
 rtl/cuckoo_index_gen.sv | 15 +
 rtl/cuckoo_req_frontend.sv | 191 +++++++++++++++++++
 tb/tb_cuckoo_req_frontend.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cuckoo_pkg.sv
// Shared constants, request payload and FSM state for the cuckoo hash front-end.
package cuckoo_pkg;

   localparam int unsigned KEY_WIDTH    = 33;
   localparam int unsigned VALUE_WIDTH  = 32;
   localparam int unsigned OFFSET_WIDTH = 3;
   localparam int unsigned TABLE_SIZE   = 50;
   localparam int unsigned IDX_WIDTH    = $clog2(TABLE_SIZE);
   localparam int unsigned FIFO_DEPTH   = 4;
   localparam int unsigned MAX_RETRY    = 3;

   localparam logic [31:0] HASH_MASK1 = 32'hFFFF_FFFF;
   localparam logic [31:0] HASH_MASK2 = 32'hAAAA_AAAA;

   typedef struct packed {
      logic [KEY_WIDTH-1:0]    key;
      logic [OFFSET_WIDTH-1:0] offset;
      logic [VALUE_WIDTH-1:0]  value;
   } req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HASH  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_CHECK = 2'd3
   } state_e;

endpackage

// File: rtl/cuckoo_index_gen.sv
// Combinational bucket-index hash: low 32 key bits to one index per way.
module cuckoo_index_gen
   import cuckoo_pkg::*;
(
   input  logic [31:0]          key_i,
   output logic [IDX_WIDTH-1:0] idx0_o,
   output logic [IDX_WIDTH-1:0] idx1_o,
   output logic [IDX_WIDTH-1:0] idx2_o
);

   assign idx0_o = IDX_WIDTH'(key_i % TABLE_SIZE);
   assign idx1_o = IDX_WIDTH'((key_i ^ HASH_MASK1) % TABLE_SIZE);
   assign idx2_o = IDX_WIDTH'((key_i ^ HASH_MASK2) % TABLE_SIZE);

endmodule

// File: rtl/cuckoo_req_frontend.sv
// Request front-end for the cuckoo table: zero-key filter, request FIFO, index
// precompute and retrying issue FSM. CUCKOO_FE_STATS_EN adds saturating counters.
module cuckoo_req_frontend
   import cuckoo_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [KEY_WIDTH-1:0]    in_key_i,
   input  logic [OFFSET_WIDTH-1:0] in_offset_i,
   input  logic [VALUE_WIDTH-1:0]  in_value_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [KEY_WIDTH-1:0]    out_key_o,
   output logic [OFFSET_WIDTH-1:0] out_offset_o,
   output logic [VALUE_WIDTH-1:0]  out_value_o,
   output logic [IDX_WIDTH-1:0]    out_idx0_o,
   output logic [IDX_WIDTH-1:0]    out_idx1_o,
   output logic [IDX_WIDTH-1:0]    out_idx2_o,
   input  logic                    tbl_collision_i,
   output logic                    err_zero_key_o,
   output logic                    drop_o
`ifdef CUCKOO_FE_STATS_EN
   ,
   output logic [15:0]             stat_issued_o,
   output logic [15:0]             stat_retries_o,
   output logic [15:0]             stat_drops_o
`endif
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

   req_t                 fifo_mem [FIFO_DEPTH];
   req_t                 in_req;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 in_ready_q, in_ready_d;
   state_e               state_q, state_d;
   req_t                 req_q, req_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic                 out_valid_q, out_valid_d;
   logic [IDX_WIDTH-1:0] idx0_q, idx0_d, idx1_q, idx1_d, idx2_q, idx2_d;
   logic [IDX_WIDTH-1:0] gen_idx0, gen_idx1, gen_idx2;
   logic                 err_q, err_d, drop_q, drop_d;
   logic                 accept, push, pop, issue_hs, retry_ev;

   cuckoo_index_gen u_index_gen (
      .key_i  (req_q.key[31:0]),
      .idx0_o (gen_idx0),
      .idx1_o (gen_idx1),
      .idx2_o (gen_idx2)
   );

   assign in_req   = '{key: in_key_i, offset: in_offset_i, value: in_value_i};
   assign accept   = in_valid_i && in_ready_q;
   assign push     = accept && (in_key_i != '0);
   assign issue_hs = out_valid_q && out_ready_i;

   // Next-state: issue FSM plus FIFO bookkeeping. The head stays queued until CHECK resolves.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      retry_d     = retry_q;
      out_valid_d = out_valid_q;
      idx0_d      = idx0_q;
      idx1_d      = idx1_q;
      idx2_d      = idx2_q;
      drop_d      = 1'b0;
      pop         = 1'b0;
      retry_ev    = 1'b0;
      err_d       = accept && (in_key_i == '0);

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               state_d = ST_HASH;
               req_d   = fifo_mem[rd_ptr_q];
               retry_d = '0;
            end
         end
         ST_HASH: begin
            state_d     = ST_ISSUE;
            out_valid_d = 1'b1;
            idx0_d      = gen_idx0;
            idx1_d      = gen_idx1;
            idx2_d      = gen_idx2;
         end
         ST_ISSUE: begin
            if (out_ready_i) begin
               state_d     = ST_CHECK;
               out_valid_d = 1'b0;
            end
         end
         ST_CHECK: begin
            if (!tbl_collision_i) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
               retry_ev    = 1'b1;
               retry_d     = retry_q + RETRY_W'(1);
               out_valid_d = 1'b1;
               state_d     = ST_ISSUE;
            end else begin
               pop     = 1'b1;
               drop_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      in_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         req_q       <= '0;
         retry_q     <= '0;
         out_valid_q <= 1'b0;
         idx0_q      <= '0;
         idx1_q      <= '0;
         idx2_q      <= '0;
         err_q       <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         req_q       <= req_d;
         retry_q     <= retry_d;
         out_valid_q <= out_valid_d;
         idx0_q      <= idx0_d;
         idx1_q      <= idx1_d;
         idx2_q      <= idx2_d;
         err_q       <= err_d;
         drop_q      <= drop_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= in_req;
   end

   assign in_ready_o     = in_ready_q;
   assign out_valid_o    = out_valid_q;
   assign out_key_o      = req_q.key;
   assign out_offset_o   = req_q.offset;
   assign out_value_o    = req_q.value;
   assign out_idx0_o     = idx0_q;
   assign out_idx1_o     = idx1_q;
   assign out_idx2_o     = idx2_q;
   assign err_zero_key_o = err_q;
   assign drop_o         = drop_q;

`ifdef CUCKOO_FE_STATS_EN
   localparam int unsigned STAT_W = 16;

   logic [STAT_W-1:0] stat_issued_q, stat_retries_q, stat_drops_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issued_q  <= '0;
         stat_retries_q <= '0;
         stat_drops_q   <= '0;
      end else begin
         if (issue_hs && (stat_issued_q != '1))  stat_issued_q  <= stat_issued_q + STAT_W'(1);
         if (retry_ev && (stat_retries_q != '1)) stat_retries_q <= stat_retries_q + STAT_W'(1);
         if (drop_d && (stat_drops_q != '1))     stat_drops_q   <= stat_drops_q + STAT_W'(1);
      end
   end

   assign stat_issued_o  = stat_issued_q;
   assign stat_retries_o = stat_retries_q;
   assign stat_drops_o   = stat_drops_q;
`endif

endmodule

// File: tb/tb_cuckoo_req_frontend.sv
// Self-checking bench for cuckoo_req_frontend: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_cuckoo_req_frontend;
   import cuckoo_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid, in_ready;
   logic [KEY_WIDTH-1:0]    in_key;
   logic [OFFSET_WIDTH-1:0] in_offset;
   logic [VALUE_WIDTH-1:0]  in_value;
   logic                    out_valid, out_ready;
   logic [KEY_WIDTH-1:0]    out_key;
   logic [OFFSET_WIDTH-1:0] out_offset;
   logic [VALUE_WIDTH-1:0]  out_value;
   logic [IDX_WIDTH-1:0]    out_idx0, out_idx1, out_idx2;
   logic                    tbl_collision, err_zero_key, drop;
`ifdef CUCKOO_FE_STATS_EN
   logic [15:0]             stat_issued, stat_retries, stat_drops;
`endif

   int checks   = 0;
   int failures = 0;

   cuckoo_req_frontend dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid_i      (in_valid),
      .in_ready_o      (in_ready),
      .in_key_i        (in_key),
      .in_offset_i     (in_offset),
      .in_value_i      (in_value),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .out_key_o       (out_key),
      .out_offset_o    (out_offset),
      .out_value_o     (out_value),
      .out_idx0_o      (out_idx0),
      .out_idx1_o      (out_idx1),
      .out_idx2_o      (out_idx2),
      .tbl_collision_i (tbl_collision),
      .err_zero_key_o  (err_zero_key),
      .drop_o          (drop)
`ifdef CUCKOO_FE_STATS_EN
      ,
      .stat_issued_o   (stat_issued),
      .stat_retries_o  (stat_retries),
      .stat_drops_o    (stat_drops)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [KEY_WIDTH-1:0]    key;
      logic [OFFSET_WIDTH-1:0] off;
      logic [VALUE_WIDTH-1:0]  val;
      logic [IDX_WIDTH-1:0]    i0, i1, i2;
   } vec_t;

   vec_t vecs[6];
   req_t exp_q[$];
   req_t mq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [IDX_WIDTH-1:0] ref_idx(input logic [31:0] k, input logic [31:0] mask);
      longint unsigned v;
      v = 64'(k ^ mask);
      return IDX_WIDTH'(v % 64'd50);
   endfunction

   function automatic req_t mk(input logic [KEY_WIDTH-1:0] k, input logic [OFFSET_WIDTH-1:0] o,
                               input logic [VALUE_WIDTH-1:0] v);
      req_t r;
      r.key = k; r.offset = o; r.value = v;
      return r;
   endfunction

   task automatic chk_out(input string tag, input req_t r);
      chk({tag, ".key"},  64'(out_key),    64'(r.key));
      chk({tag, ".off"},  64'(out_offset), 64'(r.offset));
      chk({tag, ".val"},  64'(out_value),  64'(r.value));
      chk({tag, ".idx0"}, 64'(out_idx0),   64'(ref_idx(r.key[31:0], 32'h0)));
      chk({tag, ".idx1"}, 64'(out_idx1),   64'(ref_idx(r.key[31:0], 32'hFFFF_FFFF)));
      chk({tag, ".idx2"}, 64'(out_idx2),   64'(ref_idx(r.key[31:0], 32'hAAAA_AAAA)));
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!out_valid && n < budget) begin step(); n++; end
      checks++;
      if (!out_valid) begin
         failures++;
         $display("FAIL %s: out_valid not seen within %0d cycles", tag, budget);
      end
   endtask

   task automatic send(input req_t r);
      int n = 0;
      in_valid = 1'b1; in_key = r.key; in_offset = r.offset; in_value = r.value;
      while (!in_ready && n < 50) begin step(); n++; end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL send: in_ready stuck low, got %0b expected 1", in_ready);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tbl_collision = 1'b0;
      in_key = '0; in_offset = '0; in_value = '0;
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      int issues, drops, acc_n;
      logic acc, hs, coll, pend, exp_drop, exp_err;
      int retries;
      logic [63:0] r64;

      // ---------------- reset state ----------------
      do_reset();
      chk("reset.in_ready",  64'(in_ready),     64'd1);
      chk("reset.out_valid", 64'(out_valid),    64'd0);
      chk("reset.err",       64'(err_zero_key), 64'd0);
      chk("reset.drop",      64'(drop),         64'd0);
      chk("reset.out_key",   64'(out_key),      64'd0);
      chk("reset.idx0",      64'(out_idx0),     64'd0);

      // ---------------- vector table: single requests, latency and indices ----------------
      vecs[0] = '{33'd7,             3'd2, 32'h0000_DEAD, 6'd7,  6'd38, 6'd33};
      vecs[1] = '{33'd1,             3'd0, 32'h1111_1111, 6'd1,  6'd44, 6'd31};
      vecs[2] = '{33'd50,            3'd7, 32'h2222_2222, 6'd0,  6'd45, 6'd12};
      vecs[3] = '{33'h1_0000_0031,   3'd5, 32'hCAFE_F00D, 6'd49, 6'd46, 6'd15};
      vecs[4] = '{33'h0_FFFF_FFFF,   3'd1, 32'h0BAD_BEEF, 6'd45, 6'd0,  6'd15};
      vecs[5] = '{33'h0_AAAA_AAAA,   3'd3, 32'hFFFF_FFFF, 6'd30, 6'd15, 6'd0};
      for (int i = 0; i < 6; i++) begin
         out_ready = 1'b1; tbl_collision = 1'b0;
         chk("vec.in_ready", 64'(in_ready), 64'd1);
         in_valid = 1'b1; in_key = vecs[i].key; in_offset = vecs[i].off; in_value = vecs[i].val;
         step();
         in_valid = 1'b0;
         step();
         chk("vec.lat_e1", 64'(out_valid), 64'd0);
         step();
         chk("vec.lat_e2", 64'(out_valid), 64'd1);
         chk("vec.key",  64'(out_key),    64'(vecs[i].key));
         chk("vec.off",  64'(out_offset), 64'(vecs[i].off));
         chk("vec.val",  64'(out_value),  64'(vecs[i].val));
         chk("vec.idx0", 64'(out_idx0),   64'(vecs[i].i0));
         chk("vec.idx1", 64'(out_idx1),   64'(vecs[i].i1));
         chk("vec.idx2", 64'(out_idx2),   64'(vecs[i].i2));
         step();
         chk("vec.check_valid", 64'(out_valid), 64'd0);
         step();
         chk("vec.drop", 64'(drop), 64'd0);
         step();
         chk("vec.idle_valid", 64'(out_valid), 64'd0);
      end

      // ---------------- zero key rejection ----------------
      in_valid = 1'b1; in_key = '0; in_offset = 3'd4; in_value = 32'h1234;
      step();
      in_valid = 1'b0;
      chk("zero.err_pulse", 64'(err_zero_key), 64'd1);
      step();
      chk("zero.err_clear", 64'(err_zero_key), 64'd0);
      for (int i = 0; i < 4; i++) begin
         chk("zero.no_issue", 64'(out_valid), 64'd0);
         chk("zero.in_ready", 64'(in_ready),  64'd1);
         step();
      end

      // ---------------- collision held: 1 + MAX_RETRY issues then drop ----------------
      out_ready = 1'b0;
      send(mk(33'h1234, 3'd1, 32'hA5A5_0001));
      send(mk(33'h5678, 3'd6, 32'hA5A5_0002));
      out_ready = 1'b1; tbl_collision = 1'b1;
      issues = 0; drops = 0;
      for (int n = 0; n < 40; n++) begin
         if (out_valid) begin
            chk("coll.key", 64'(out_key), 64'h1234);
            issues++;
         end
         if (drop) begin drops++; break; end
         step();
      end
      tbl_collision = 1'b0;
      chk("coll.issues", 64'(issues), 64'd4);
      chk("coll.drops",  64'(drops),  64'd1);
      step();
      chk("coll.drop_one_cycle", 64'(drop), 64'd0);
      wait_valid("coll.next", 10);
      chk_out("coll.next", mk(33'h5678, 3'd6, 32'hA5A5_0002));
      step(); step();
      chk("coll.after_drop", 64'(drop), 64'd0);
      repeat (2) step();

      // ---------------- back-to-back with backpressure, then ordered drain ----------------
      out_ready = 1'b0; tbl_collision = 1'b0;
      exp_q.delete();
      acc_n = 0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_key = KEY_WIDTH'(100 + i); in_offset = OFFSET_WIDTH'(i);
         in_value = $urandom();
         chk("bp.in_ready", 64'(in_ready), 64'(i < 4));
         if (in_ready) begin exp_q.push_back(mk(in_key, in_offset, in_value)); acc_n++; end
         step();
      end
      in_valid = 1'b0;
      chk("bp.accepted", 64'(acc_n), 64'd4);
      wait_valid("bp.first", 10);
      for (int i = 0; i < 3; i++) begin
         chk_out("bp.hold", exp_q[0]);
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_valid("bp.drain", 10);
         chk_out("bp.drain", exp_q[i]);
         step(); step();
      end
      chk("bp.empty_ready", 64'(in_ready), 64'd1);

      // ---------------- reset asserted during ISSUE with 3 queued ----------------
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(mk(KEY_WIDTH'(200 + i), 3'd0, 32'h0));
      wait_valid("rst.issue", 10);
      #2 rst = 1'b1;
      #1;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.in_ready",  64'(in_ready),  64'd1);
      chk("rst.out_key",   64'(out_key),   64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("rst.fifo_empty", 64'(out_valid), 64'd0);
         step();
      end
      out_ready = 1'b1;
      send(mk(33'h1_2345_6789, 3'd2, 32'h5555_AAAA));
      wait_valid("rst.after", 10);
      chk_out("rst.after", mk(33'h1_2345_6789, 3'd2, 32'h5555_AAAA));
      step(); step();

      // ---------------- randomized run against the queue model ----------------
      do_reset();
      mq.delete(); pend = 1'b0; retries = 0;
      for (int cyc = 0; cyc < 3200; cyc++) begin
         if (cyc < 3000) begin
            in_valid = ($urandom_range(0, 2) != 0);
            r64 = {$urandom(), $urandom()};
            in_key = ($urandom_range(0, 5) == 0) ? '0 : KEY_WIDTH'(r64);
            in_offset = OFFSET_WIDTH'($urandom());
            in_value = $urandom();
         end else begin
            in_valid = 1'b0;
         end
         out_ready     = ($urandom_range(0, 3) != 0);
         tbl_collision = ($urandom_range(0, 2) == 0);

         chk("rand.in_ready", 64'(in_ready), 64'(mq.size() < FIFO_DEPTH));
         acc = in_valid && (mq.size() < FIFO_DEPTH);
         hs  = out_valid && out_ready;
         if (hs) begin
            if (mq.size() == 0) begin
               checks++; failures++;
               $display("FAIL rand.spurious_issue: got key 0x%0h, expected no issue", out_key);
            end else begin
               chk_out("rand.issue", mq[0]);
            end
         end
         coll = tbl_collision;
         exp_err = acc && (in_key == '0);
         exp_drop = 1'b0;
         step();

         if (pend) begin
            pend = 1'b0;
            if (!coll) begin
               void'(mq.pop_front()); retries = 0;
            end else if (retries < MAX_RETRY) begin
               retries++;
            end else begin
               void'(mq.pop_front()); retries = 0; exp_drop = 1'b1;
            end
         end
         if (hs) pend = 1'b1;
         if (acc && !exp_err) mq.push_back(mk(in_key, in_offset, in_value));
         chk("rand.err",  64'(err_zero_key), 64'(exp_err));
         chk("rand.drop", 64'(drop),         64'(exp_drop));
      end
      chk("rand.drained",   64'(mq.size()), 64'd0);
      chk("rand.end_valid", 64'(out_valid), 64'd0);

`ifdef CUCKOO_FE_STATS_EN
      // ---------------- statistics counters ----------------
      do_reset();
      out_ready = 1'b1; tbl_collision = 1'b0;
      send(mk(33'd11, 3'd0, 32'd1));
      send(mk(33'd12, 3'd0, 32'd2));
      repeat (20) step();
      tbl_collision = 1'b1;
      send(mk(33'd13, 3'd0, 32'd3));
      for (int n = 0; n < 40 && !drop; n++) step();
      tbl_collision = 1'b0;
      step();
      chk("stats.issued",  64'(stat_issued),  64'd6);
      chk("stats.retries", 64'(stat_retries), 64'd3);
      chk("stats.drops",   64'(stat_drops),   64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
